// File: rtl/jelly3_axi4l_if.sv
// AXI4-Lite bus bundle shared by the register-write master and the region-rect register file.
// Carries no clock or reset; both ends run on the owner's aclk/aresetn.
interface jelly3_axi4l_if #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
);
    logic [ADDR_BITS-1:0]   awaddr;
    logic [2:0]             awprot;
    logic                   awvalid;
    logic                   awready;
    logic [DATA_BITS-1:0]   wdata;
    logic [DATA_BITS/8-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    logic [ADDR_BITS-1:0]   araddr;
    logic [2:0]             arprot;
    logic                   arvalid;
    logic                   arready;
    logic [DATA_BITS-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport m (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport s (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/jelly3_img_region_rect_sequencer.sv
// Per-frame ROI scheduler: on each frame start, writes the next table entry into the region-rect
// registers over AXI4-Lite and pulses update_req. Define JELLY3_IMG_REGION_RECT_SEQ_POLL_EN to poll CTL_CONTROL.
module jelly3_img_region_rect_sequencer #(
    parameter int          ROI_NUM  = 4,
    parameter int          X_BITS   = 11,
    parameter int          Y_BITS   = 10,
    parameter logic [63:0] REG_BASE = '0,
    localparam int         IDX_BITS = (ROI_NUM > 1) ? $clog2(ROI_NUM) : 1
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                enable,
    input  logic [IDX_BITS:0]   roi_num,
    input  logic                frame_start,
    input  logic                tbl_we,
    input  logic [IDX_BITS-1:0] tbl_addr,
    input  logic [X_BITS-1:0]   tbl_x,
    input  logic [Y_BITS-1:0]   tbl_y,
    input  logic [X_BITS-1:0]   tbl_width,
    input  logic [Y_BITS-1:0]   tbl_height,
    jelly3_axi4l_if.m           m_axi4l,
    output logic                busy,
    output logic                update_req,
    output logic [IDX_BITS-1:0] roi_index,
    output logic [15:0]         overrun_count
);
    localparam int ADDR_BITS = $bits(m_axi4l.awaddr);
    localparam int DATA_BITS = $bits(m_axi4l.wdata);

    typedef logic [X_BITS-1:0]   x_t;
    typedef logic [Y_BITS-1:0]   y_t;
    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [IDX_BITS:0]   num_t;

    localparam int REG_CTL_CONTROL  = 'h04;
    localparam int REG_PARAM_X      = 'h08;
    localparam int REG_PARAM_Y      = 'h09;
    localparam int REG_PARAM_WIDTH  = 'h0a;
    localparam int REG_PARAM_HEIGHT = 'h0b;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_WR_X    = 4'd1;
    localparam logic [3:0] ST_WR_Y    = 4'd2;
    localparam logic [3:0] ST_WR_W    = 4'd3;
    localparam logic [3:0] ST_WR_H    = 4'd4;
    localparam logic [3:0] ST_WR_CTL  = 4'd5;
    localparam logic [3:0] ST_DONE    = 4'd6;
`ifdef JELLY3_IMG_REGION_RECT_SEQ_POLL_EN
    localparam logic [3:0] ST_POLL_AR = 4'd7;
    localparam logic [3:0] ST_POLL_R  = 4'd8;
`endif

    function automatic logic [ADDR_BITS-1:0] reg_addr(input int word);
        reg_addr = ADDR_BITS'(REG_BASE + 64'(word) * 64'(DATA_BITS / 8));
    endfunction

    x_t tbl_x_q [ROI_NUM];
    y_t tbl_y_q [ROI_NUM];
    x_t tbl_w_q [ROI_NUM];
    y_t tbl_h_q [ROI_NUM];

    logic [3:0]           state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 update_req_q, update_req_d;
    idx_t                 roi_index_q, roi_index_d;
    idx_t                 cur_idx_q, cur_idx_d;
    logic [15:0]          overrun_q, overrun_d;
    x_t                   shd_x_q, shd_x_d, shd_w_q, shd_w_d;
    y_t                   shd_y_q, shd_y_d, shd_h_q, shd_h_d;
    logic                 awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic [ADDR_BITS-1:0] awaddr_q, awaddr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
`ifdef JELLY3_IMG_REGION_RECT_SEQ_POLL_EN
    logic                 arvalid_q, arvalid_d;
`endif

    num_t eff_roi_num;
    idx_t sel_idx;
    logic bypass;
    logic wr_done;
    logic issue_wr;

    // NOTE: every *_d gets a default before any branch so no path can infer a latch.
    always_comb begin
        eff_roi_num = (roi_num == '0) ? num_t'(1)
                    : (roi_num > num_t'(ROI_NUM)) ? num_t'(ROI_NUM) : roi_num;
        // An index stranded by a shrunk roi_num restarts the rotation at entry 0.
        sel_idx     = ({1'b0, cur_idx_q} >= eff_roi_num) ? '0 : cur_idx_q;
        bypass      = tbl_we && (tbl_addr == sel_idx);
        wr_done     = !awvalid_q && !wvalid_q && m_axi4l.bvalid;

        state_d      = state_q;
        busy_d       = busy_q;
        update_req_d = 1'b0;
        roi_index_d  = roi_index_q;
        cur_idx_d    = cur_idx_q;
        overrun_d    = overrun_q;
        shd_x_d      = shd_x_q;
        shd_y_d      = shd_y_q;
        shd_w_d      = shd_w_q;
        shd_h_d      = shd_h_q;
        awvalid_d    = awvalid_q && !m_axi4l.awready;
        wvalid_d     = wvalid_q && !m_axi4l.wready;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        issue_wr     = 1'b0;
`ifdef JELLY3_IMG_REGION_RECT_SEQ_POLL_EN
        arvalid_d    = arvalid_q && !m_axi4l.arready;
`endif

        if (frame_start && busy_q && overrun_q != 16'hffff) begin
            overrun_d = overrun_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start && enable) begin
                    shd_x_d   = bypass ? tbl_x      : tbl_x_q[sel_idx];
                    shd_y_d   = bypass ? tbl_y      : tbl_y_q[sel_idx];
                    shd_w_d   = bypass ? tbl_width  : tbl_w_q[sel_idx];
                    shd_h_d   = bypass ? tbl_height : tbl_h_q[sel_idx];
                    cur_idx_d = sel_idx;
                    busy_d    = 1'b1;
                    state_d   = ST_WR_X;
                    issue_wr  = 1'b1;
                end
            end
            ST_WR_X, ST_WR_Y, ST_WR_W, ST_WR_H: begin
                if (wr_done) begin
                    state_d  = state_q + 4'd1;
                    issue_wr = 1'b1;
                end
            end
            ST_WR_CTL: begin
                if (wr_done) begin
`ifdef JELLY3_IMG_REGION_RECT_SEQ_POLL_EN
                    state_d   = ST_POLL_AR;
                    arvalid_d = 1'b1;
`else
                    state_d   = ST_DONE;
`endif
                end
            end
`ifdef JELLY3_IMG_REGION_RECT_SEQ_POLL_EN
            ST_POLL_AR: begin
                if (arvalid_q && m_axi4l.arready) state_d = ST_POLL_R;
            end
            ST_POLL_R: begin
                if (m_axi4l.rvalid) begin
                    // Update bit still set: the core has not consumed it yet.
                    if (m_axi4l.rdata[1]) begin
                        state_d   = ST_POLL_AR;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = ST_DONE;
                    end
                end
            end
`endif
            ST_DONE: begin
                update_req_d = 1'b1;
                roi_index_d  = cur_idx_q;
                cur_idx_d    = ({1'b0, cur_idx_q} + num_t'(1) == eff_roi_num) ? '0 : cur_idx_q + idx_t'(1);
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            case (state_d)
                ST_WR_X:   begin awaddr_d = reg_addr(REG_PARAM_X);      wdata_d = DATA_BITS'(shd_x_d); end
                ST_WR_Y:   begin awaddr_d = reg_addr(REG_PARAM_Y);      wdata_d = DATA_BITS'(shd_y_d); end
                ST_WR_W:   begin awaddr_d = reg_addr(REG_PARAM_WIDTH);  wdata_d = DATA_BITS'(shd_w_d); end
                ST_WR_H:   begin awaddr_d = reg_addr(REG_PARAM_HEIGHT); wdata_d = DATA_BITS'(shd_h_d); end
                ST_WR_CTL: begin awaddr_d = reg_addr(REG_CTL_CONTROL);  wdata_d = DATA_BITS'(2'b11);   end
                default:   begin awaddr_d = awaddr_q;                   wdata_d = wdata_q;             end
            endcase
        end
    end

    // NOTE: the table is small and must read back as zero after reset, so it is built from
    // resettable flops rather than an inferred RAM.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < ROI_NUM; i++) begin
                tbl_x_q[i] <= '0;
                tbl_y_q[i] <= '0;
                tbl_w_q[i] <= '0;
                tbl_h_q[i] <= '0;
            end
        end else if (tbl_we && int'(tbl_addr) < ROI_NUM) begin
            tbl_x_q[tbl_addr] <= tbl_x;
            tbl_y_q[tbl_addr] <= tbl_y;
            tbl_w_q[tbl_addr] <= tbl_width;
            tbl_h_q[tbl_addr] <= tbl_height;
        end
    end

    // NOTE: sequential state is committed only with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            update_req_q <= 1'b0;
            roi_index_q  <= '0;
            cur_idx_q    <= '0;
            overrun_q    <= '0;
            shd_x_q      <= '0;
            shd_y_q      <= '0;
            shd_w_q      <= '0;
            shd_h_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            update_req_q <= update_req_d;
            roi_index_q  <= roi_index_d;
            cur_idx_q    <= cur_idx_d;
            overrun_q    <= overrun_d;
            shd_x_q      <= shd_x_d;
            shd_y_q      <= shd_y_d;
            shd_w_q      <= shd_w_d;
            shd_h_q      <= shd_h_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
        end
    end

`ifdef JELLY3_IMG_REGION_RECT_SEQ_POLL_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) arvalid_q <= 1'b0;
        else          arvalid_q <= arvalid_d;
    end
    assign m_axi4l.arvalid = arvalid_q;
`else
    assign m_axi4l.arvalid = 1'b0;
`endif

    assign m_axi4l.awaddr  = awaddr_q;
    assign m_axi4l.awprot  = '0;
    assign m_axi4l.awvalid = awvalid_q;
    assign m_axi4l.wdata   = wdata_q;
    assign m_axi4l.wstrb   = '1;
    assign m_axi4l.wvalid  = wvalid_q;
    assign m_axi4l.bready  = 1'b1;
    assign m_axi4l.araddr  = reg_addr(REG_CTL_CONTROL);
    assign m_axi4l.arprot  = '0;
    assign m_axi4l.rready  = 1'b1;

    assign busy          = busy_q;
    assign update_req    = update_req_q;
    assign roi_index     = roi_index_q;
    assign overrun_count = overrun_q;

    // Response codes are ignored; the read path is only consulted in the polling build.
    logic unused_axi;
    assign unused_axi = ^{m_axi4l.bresp, m_axi4l.rresp, m_axi4l.rdata, m_axi4l.arready, m_axi4l.rvalid};
endmodule
